// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared definitions for the ALU sequencer. Holds the opcode
//            constants, the sequencer state type and the register index
//            width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

   localparam int REG_IDX_W = 3;

   localparam logic [3:0] OP_ADD       = 4'b0000;
   localparam logic [3:0] OP_SUB       = 4'b0001;
   localparam logic [3:0] OP_SHL       = 4'b0111;
   localparam logic [3:0] OP_EQ        = 4'b1100;
   localparam logic [3:0] OP_LDI       = 4'b1111;
   localparam logic [3:0] OP_IDLE_CTRL = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Opcodes 0000..1100 are forwarded to the external ALU.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op <= OP_EQ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_regfile
// Purpose  : NREG x 8-bit register file, two asynchronous read ports and one
//            synchronous write port. All entries clear on rst_n low.
// Ports    : clk, rst_n          clock, async active-low clear
//            ra_addr / ra_data   read port A
//            rb_addr / rb_data   read port B
//            we, wa, wd          write enable, address, data
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] ra_addr,
   output logic [7:0]           ra_data,
   input  logic [REG_IDX_W-1:0] rb_addr,
   output logic [7:0]           rb_data,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] wa,
   input  logic [7:0]           wd
);

   logic [7:0] r_mem [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else if (we) begin
         r_mem[wa] <= wd;
      end
   end

   assign ra_data = r_mem[ra_addr];
   assign rb_data = r_mem[rb_addr];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle initiator for an external 8-bit combinational ALU.
//            Accepts one instruction at a time, reads operands from an
//            internal register file, issues the ALU operation for one cycle,
//            writes the result back and returns it on a response channel.
// Ports    : clk, rst_n                   clock, async active-low reset
//            instr_valid/ready/op/rd/rs/rt/imm   instruction channel
//            alu_ctrl/x/y (out), alu_out/carry (in)   ALU connection
//            res_valid/ready/data/carry/rd/err   response channel
// Revision : 1.0  initial release
// ============================================================================
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [3:0]           instr_op,
   input  logic [REG_IDX_W-1:0] instr_rd,
   input  logic [REG_IDX_W-1:0] instr_rs,
   input  logic [REG_IDX_W-1:0] instr_rt,
   input  logic [7:0]           instr_imm,
   output logic [3:0]           alu_ctrl,
   output logic [7:0]           alu_x,
   output logic [7:0]           alu_y,
   input  logic [7:0]           alu_out,
   input  logic                 alu_carry,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [7:0]           res_data,
   output logic                 res_carry,
   output logic [REG_IDX_W-1:0] res_rd,
   output logic                 res_err
);

   state_t               r_state;
   state_t               w_next;
   logic                 w_accept;
   logic                 w_we;
   logic [REG_IDX_W-1:0] w_wa;
   logic [7:0]           w_wd;
   logic [7:0]           w_rs_data;
   logic [7:0]           w_rt_data;

   logic [3:0]           r_alu_ctrl;
   logic [7:0]           r_alu_x;
   logic [7:0]           r_alu_y;
   logic [7:0]           r_res_data;
   logic                 r_res_carry;
   logic [REG_IDX_W-1:0] r_res_rd;
   logic                 r_res_err;

   alu_seq_regfile #(
      .NREG (NREG)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (instr_rs),
      .ra_data (w_rs_data),
      .rb_addr (instr_rt),
      .rb_data (w_rt_data),
      .we      (w_we),
      .wa      (w_wa),
      .wd      (w_wd)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (instr_valid) begin
               w_next = is_alu_op(instr_op) ? ST_EXEC : ST_RESP;
            end
         end
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: begin
            if (res_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Output / control decode. instr_ready depends on state only.
   always_comb begin
      instr_ready = (r_state == ST_IDLE);
      res_valid   = (r_state == ST_RESP);
      w_accept    = (r_state == ST_IDLE) && instr_valid;
      // Single write port: ALU results land at the end of EXEC, LDI at
      // its accept edge. The two can never coincide.
      w_we        = 1'b0;
      w_wa        = instr_rd;
      w_wd        = instr_imm;
      if (r_state == ST_EXEC) begin
         w_we = 1'b1;
         w_wa = r_res_rd;
         w_wd = alu_out;
      end else if (w_accept && (instr_op == OP_LDI)) begin
         w_we = 1'b1;
      end
   end

   // Datapath registers: ALU issue and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_ctrl  <= OP_IDLE_CTRL;
         r_alu_x     <= 8'h00;
         r_alu_y     <= 8'h00;
         r_res_data  <= 8'h00;
         r_res_carry <= 1'b0;
         r_res_rd    <= '0;
         r_res_err   <= 1'b0;
      end else if (w_accept) begin
         r_res_rd <= instr_rd;
         if (is_alu_op(instr_op)) begin
            // Operands sampled here, before any write-back, so aliased
            // rd/rs/rt see the old register value.
            r_alu_ctrl <= instr_op;
            r_alu_x    <= w_rs_data;
            r_alu_y    <= w_rt_data;
            r_res_err  <= 1'b0;
         end else if (instr_op == OP_LDI) begin
            r_res_data  <= instr_imm;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b0;
         end else begin
            r_res_data  <= 8'h00;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b1;
         end
      end else if (r_state == ST_EXEC) begin
         r_res_data  <= alu_out;
         r_res_carry <= alu_carry;
         r_alu_ctrl  <= OP_IDLE_CTRL;
         r_alu_x     <= 8'h00;
         r_alu_y     <= 8'h00;
      end
   end

   assign alu_ctrl  = r_alu_ctrl;
   assign alu_x     = r_alu_x;
   assign alu_y     = r_alu_y;
   assign res_data  = r_res_data;
   assign res_carry = r_res_carry;
   assign res_rd    = r_res_rd;
   assign res_err   = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Provides a behavioural
//            ALU on the alu_* ports and an instruction-level reference model
//            (register array) for expected responses.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [2:0] instr_rd, instr_rs, instr_rt;
   logic [7:0] instr_imm;
   logic [3:0] alu_ctrl;
   logic [7:0] alu_x, alu_y, alu_out;
   logic       alu_carry;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic [2:0] res_rd;
   logic       res_err;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] mdl_r [8];

   always #5 clk = ~clk;

   alu_sequencer #(.NREG(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs    (instr_rs),
      .instr_rt    (instr_rt),
      .instr_imm   (instr_imm),
      .alu_ctrl    (alu_ctrl),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_out     (alu_out),
      .alu_carry   (alu_carry),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_carry   (res_carry),
      .res_rd      (res_rd),
      .res_err     (res_err)
   );

   // Behavioural ALU: returns {carry, out}
   function automatic logic [8:0] alu_model(input logic [3:0] c,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
      case (c)
         4'd0:    return {1'b0, x} + {1'b0, y};
         4'd1:    return {(x < y), 8'(x - y)};
         4'd2:    return {1'b0, x & y};
         4'd3:    return {1'b0, x | y};
         4'd4:    return {1'b0, x ^ y};
         4'd5:    return {1'b0, ~x};
         4'd6:    return {x[0], 1'b0, x[7:1]};
         4'd7:    return 9'({1'b0, y} << x[2:0]);
         4'd8:    return {1'b0, x} + {1'b0, y} + 9'd1;
         4'd9:    return {1'b0, 8'(x - y - 8'd1)};
         4'd10:   return {1'b0, x} + 9'd1;
         4'd11:   return {(x == 8'h00), 8'(x - 8'd1)};
         4'd12:   return {1'b0, 7'd0, (x == y)};
         default: return 9'd0;
      endcase
   endfunction

   assign {alu_carry, alu_out} = alu_model(alu_ctrl, alu_x, alu_y);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one instruction, checks issue/response against the model, holds
   // res_ready low for 'hold' cycles (optionally offering a second
   // instruction meanwhile), then completes the handshake.
   task automatic run_instr(input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [2:0] rt,
                            input logic [7:0] imm, input int hold,
                            input bit offer2nd);
      logic [8:0] r;
      logic [7:0] ex_d;
      logic       ex_c, ex_e;
      logic [2:0] rd2;
      int         n;
      n = 0;
      while (!instr_ready && n < 20) begin
         step();
         n++;
      end
      chk("ready_before_issue", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
      step();
      instr_valid = 1'b0;
      if (op <= 4'd12) begin
         r = alu_model(op, mdl_r[rs], mdl_r[rt]);
         ex_c = r[8]; ex_d = r[7:0]; ex_e = 1'b0;
         chk("exec_res_valid", 32'(res_valid), 32'd0);
         chk("exec_instr_ready", 32'(instr_ready), 32'd0);
         chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(op));
         chk("exec_alu_x", 32'(alu_x), 32'(mdl_r[rs]));
         chk("exec_alu_y", 32'(alu_y), 32'(mdl_r[rt]));
         step();
      end else if (op == 4'hF) begin
         ex_d = imm; ex_c = 1'b0; ex_e = 1'b0;
      end else begin
         ex_d = 8'h00; ex_c = 1'b0; ex_e = 1'b1;
      end
      chk("resp_alu_ctrl_idle", 32'(alu_ctrl), 32'hF);
      chk("resp_valid", 32'(res_valid), 32'd1);
      chk("resp_data", 32'(res_data), 32'(ex_d));
      chk("resp_carry", 32'(res_carry), 32'(ex_c));
      chk("resp_rd", 32'(res_rd), 32'(rd));
      chk("resp_err", 32'(res_err), 32'(ex_e));
      if (!ex_e) mdl_r[rd] = ex_d;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("reg_R%0d", i), 32'(dut.u_rf.r_mem[i]), 32'(mdl_r[i]));
      end
      rd2 = rd + 3'd1;
      for (int i = 0; i < hold; i++) begin
         if (offer2nd) begin
            instr_valid = 1'b1;
            instr_op = 4'hF; instr_rd = rd2; instr_imm = ~mdl_r[rd2];
         end
         step();
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_data", 32'(res_data), 32'(ex_d));
         chk("hold_carry", 32'(res_carry), 32'(ex_c));
         chk("hold_instr_ready", 32'(instr_ready), 32'd0);
      end
      instr_valid = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("after_hs_valid", 32'(res_valid), 32'd0);
      chk("after_hs_ready", 32'(instr_ready), 32'd1);
      if (offer2nd) begin
         chk("offered_not_written", 32'(dut.u_rf.r_mem[rd2]), 32'(mdl_r[rd2]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b0;
      instr_op = 4'h0; instr_rd = 3'd0; instr_rs = 3'd0; instr_rt = 3'd0; instr_imm = 8'h00;
      for (int i = 0; i < 8; i++) mdl_r[i] = 8'h00;
      step();
      step();
      // Reset state
      chk("rst_instr_ready", 32'(instr_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_carry", 32'(res_carry), 32'd0);
      chk("rst_res_rd", 32'(res_rd), 32'd0);
      chk("rst_res_err", 32'(res_err), 32'd0);
      chk("rst_alu_ctrl", 32'(alu_ctrl), 32'hF);
      chk("rst_alu_x", 32'(alu_x), 32'd0);
      chk("rst_alu_y", 32'(alu_y), 32'd0);
      rst_n = 1'b1;
      step();

      // ADD R0+R0 -> R1 after reset
      run_instr(4'h0, 3'd1, 3'd0, 3'd0, 8'h00, 0, 0);
      chk("add_zero_data", 32'(res_data), 32'h00);

      // 0x7F + 0x01
      run_instr(4'hF, 3'd1, 3'd0, 3'd0, 8'h7F, 0, 0);
      run_instr(4'hF, 3'd2, 3'd0, 3'd0, 8'h01, 0, 0);
      run_instr(4'h0, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0);
      chk("add_7f_01_data", 32'(res_data), 32'h80);
      chk("add_7f_01_R3", 32'(dut.u_rf.r_mem[3]), 32'h80);

      // SUB 0-1 borrows, then SHL
      run_instr(4'hF, 3'd4, 3'd0, 3'd0, 8'h00, 0, 0);
      run_instr(4'hF, 3'd5, 3'd0, 3'd0, 8'h01, 0, 0);
      run_instr(4'h1, 3'd6, 3'd4, 3'd5, 8'h00, 0, 0);
      chk("sub_data", 32'(res_data), 32'hFF);
      chk("sub_carry", 32'(res_carry), 32'd1);
      run_instr(4'h7, 3'd7, 3'd5, 3'd6, 8'h00, 0, 0);
      chk("shl_data", 32'(res_data), 32'hFE);

      // Illegal opcodes
      run_instr(4'hD, 3'd2, 3'd0, 3'd0, 8'h55, 0, 0);
      chk("illegal_R2_kept", 32'(dut.u_rf.r_mem[2]), 32'h01);
      run_instr(4'hE, 3'd3, 3'd1, 3'd2, 8'hAA, 1, 0);

      // Aliased operands: R3 = R3 + R3 uses old R3
      run_instr(4'h0, 3'd3, 3'd3, 3'd3, 8'h00, 0, 0);

      // Backpressure with a second instruction offered
      run_instr(4'h0, 3'd0, 3'd1, 3'd5, 8'h00, 3, 1);
      run_instr(4'hF, 3'd6, 3'd0, 3'd0, 8'h3C, 2, 1);

      // Reset during EXEC
      instr_valid = 1'b1;
      instr_op = 4'h0; instr_rd = 3'd3; instr_rs = 3'd1; instr_rt = 3'd2;
      step();
      instr_valid = 1'b0;
      chk("midexec_alu_ctrl", 32'(alu_ctrl), 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("midexec_rst_valid", 32'(res_valid), 32'd0);
      chk("midexec_rst_ready", 32'(instr_ready), 32'd1);
      chk("midexec_rst_ctrl", 32'(alu_ctrl), 32'hF);
      step();
      chk("midexec_R3_cleared", 32'(dut.u_rf.r_mem[3]), 32'h00);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mdl_r[i] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midexec_no_resp", 32'(res_valid), 32'd0);
         chk("midexec_idle", 32'(instr_ready), 32'd1);
      end

      // Randomized instruction stream
      for (int k = 0; k < 40; k++) begin
         run_instr(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle initiator for the 8-bit combinational ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8×8 register file. It drives the ALU's ctrl/x/y inputs, captures out/carry, writes the result back and returns it over a valid/ready response channel. It sits between an instruction source (testbench or simple fetch unit) and the ALU, which is instantiated alongside it and connected through the `alu_*` ports.

## Interface
- `NREG`, 8: register count (fixed 8; index width 3)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  sequencer can accept
- `instr_op`  in  4  0000–1100 ALU op (passed as ALU ctrl); 1111 LDI; 1101/1110 illegal
- `instr_rd`  in  3  destination register
- `instr_rs`  in  3  source for ALU x
- `instr_rt`  in  3  source for ALU y
- `instr_imm`  in  8  immediate for LDI
- `alu_ctrl`  out  4  to ALU ctrl
- `alu_x`  out  8  to ALU x
- `alu_y`  out  8  to ALU y
- `alu_out`  in  8  from ALU out
- `alu_carry`  in  1  from ALU carry
- `res_valid`  out  1  response present
- `res_ready`  in  1  response consumed
- `res_data`  out  8  value written (0 on error)
- `res_carry`  out  1  captured carry (0 for LDI/error)
- `res_rd`  out  3  destination of this instruction
- `res_err`  out  1  illegal opcode

## Operation
- States:
  - **IDLE**: instr_ready=1.
  - **EXEC**: ALU ports driven.
  - **RESP**: res_valid=1.
- Transitions:
  - IDLE→EXEC when instr_valid and op ≤ 1100.
  - IDLE→RESP when instr_valid and op is LDI or illegal.
  - EXEC→RESP unconditionally after one cycle.
  - RESP→IDLE when res_ready.
- Accept edge: latch op, rd, rs, rt, imm.
  - ALU op: load alu_ctrl=op, alu_x=R[rs], alu_y=R[rt] (registered).
- End of EXEC:
  - Sample alu_out/alu_carry into res_data/res_carry.
  - Write R[rd]=alu_out in the same edge.
- LDI, at the accept edge:
  - R[rd]=imm; res_data=imm; res_carry=0; res_err=0.
- Illegal 1101/1110:
  - No register write, no ALU issue.
  - res_data=0, res_carry=0, res_err=1.
- rs/rt/rd may alias. Operands are read at accept, before the write, so `R3=R3+R3` uses the old R3.
- All 8 registers are writable; there is no hardwired zero.
- Outside EXEC: alu_ctrl=4'b1111, alu_x=alu_y=0.
- res_* values are stable for the whole time res_valid is high.

## Timing
- Reset (async, rst_n low):
  - State=IDLE; all registers R0–R7=0.
  - instr_ready=1, res_valid=0, res_data=0, res_carry=0, res_rd=0, res_err=0.
  - alu_ctrl=4'b1111, alu_x=alu_y=0.
- Reset mid-EXEC or mid-RESP aborts the instruction; no write occurs after reset assertion.
- ALU op accepted at edge T:
  - EXEC during cycle T..T+1.
  - res_valid high from T+1 edge (latency 2 cycles to write-back/response).
- LDI/illegal accepted at edge T: res_valid high after edge T.
- Backpressure: res_ready low holds RESP indefinitely, with instr_ready=0.
- Throughput, with res_ready tied high:
  - One ALU instruction per 3 cycles.
  - One LDI per 2 cycles.
- instr_ready is a pure function of state (high only in IDLE); it has no combinational path from instr_valid.

## Structure
- Package `alu_seq_pkg`:
  - Opcode constants: OP_ADD=0000 … OP_EQ=1100, OP_LDI=1111, OP_IDLE_CTRL=1111.
  - State enum {IDLE, EXEC, RESP}.
  - Register index width.
- Sub-module `alu_seq_regfile`:
  - 8×8, two async read ports, one synchronous write port.
  - Async active-low clear.
- The ALU is not instantiated inside this block.

## Test plan
- Reset with rst_n low → all outputs at reset values; after release, issue ADD R0+R0→R1 → res_data=0x00, res_carry=0.
- LDI R1=0x7F, LDI R2=0x01, ADD(0000) rd=R3 rs=R1 rt=R2 → res_valid 2 cycles after accept, res_data=0x80, res_carry=0, R3=0x80.
- LDI R4=0x00, LDI R5=0x01, SUB(0001) rd=R6 rs=R4 rt=R5 → res_data=0xFF, res_carry=1; then SHL(0111) rd=R7 rs=R5 rt=R6 → res_data=0xFE.
- Op 1101 rd=R2 → res_err=1, res_data=0, R2 still 0x01; alu_ctrl stays 4'b1111 throughout.
- ALU op with res_ready low for 3 cycles → res_valid and res_data held stable, instr_ready=0, second instr_valid not accepted; accepted in the cycle after res_ready handshake.
- rst_n pulsed low during EXEC of ADD rd=R3 → R3=0, res_valid never asserts for that instruction, state IDLE.
